// File: rtl/pixel_line_packer.sv
// Packs a stream of RGB pixels into wide SRAM line words and writes one frame.
// Latency: write_enable asserts the cycle after the last slot of a line is accepted.
// Backpressure: pixel_ready drops for exactly one cycle per line (the WRITE cycle) and outside a frame.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   start, base_address   - begin a frame at base_address (accepted only in IDLE)
//   pixel_valid/_data     - upstream pixel stream, accepted when pixel_ready is high
//   pixel_ready           - high while filling a line
//   flush                 - end the frame early; a partial line is padded with all-ones and written
//   write_data, address   - packed line and its SRAM word address
//   write_enable          - one-cycle write strobe
//   busy, done            - frame in progress / one-cycle completion pulse
module pixel_line_packer #(
  parameter int PIXEL_W     = 24,
  parameter int LINE_PIXELS = 64,
  parameter int FRAME_WORDS = 3264
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [23:0]                    base_address,
  input  logic                           pixel_valid,
  input  logic [PIXEL_W-1:0]             pixel_data,
  output logic                           pixel_ready,
  input  logic                           flush,
  output logic [LINE_PIXELS*PIXEL_W-1:0] write_data,
  output logic [23:0]                    address,
  output logic                           write_enable,
  output logic                           busy,
  output logic                           done
);

  localparam int FILL_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int WORD_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [LINE_PIXELS-1:0][PIXEL_W-1:0]  line_q;
  logic [FILL_W-1:0]                    fill_cnt_q;
  logic [WORD_W-1:0]                    word_cnt_q;
  logic [23:0]                          addr_q;
  logic                                 flush_pending_q;

  logic accept;
  logic last_slot;
  logic last_word;

  assign accept    = (state_q == FILL) && pixel_valid;
  assign last_slot = (fill_cnt_q == FILL_W'(LINE_PIXELS - 1));
  assign last_word = ((word_cnt_q + WORD_W'(1)) == WORD_W'(FRAME_WORDS));

  // Outputs are decoded straight from the registered state, so they are glitch-free
  // and write_data/address are stable for the whole WRITE cycle.
  assign pixel_ready  = (state_q == FILL);
  assign write_enable = (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign write_data   = line_q;
  assign address      = addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = FILL;
      end
      FILL: begin
        if (accept && last_slot) begin
          state_d = WRITE;
        end else if (flush) begin
          // An empty line is never written; a flush that coincides with a pixel
          // still owes a write for that pixel.
          state_d = ((fill_cnt_q == '0) && !accept) ? DONE : WRITE;
        end
      end
      WRITE: begin
        state_d = (last_word || flush_pending_q) ? DONE : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q          <= '1;
      fill_cnt_q      <= '0;
      word_cnt_q      <= '0;
      addr_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q          <= base_address;
            fill_cnt_q      <= '0;
            word_cnt_q      <= '0;
            line_q          <= '1;
            flush_pending_q <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            line_q[fill_cnt_q] <= pixel_data;
            fill_cnt_q         <= fill_cnt_q + FILL_W'(1);
          end
          // Remembered so the write it triggers (or the one already due) ends the frame.
          if (flush) flush_pending_q <= 1'b1;
        end
        WRITE: begin
          addr_q          <= addr_q + 24'(LINE_PIXELS);
          word_cnt_q      <= word_cnt_q + WORD_W'(1);
          fill_cnt_q      <= '0;
          line_q          <= '1;
          flush_pending_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_line_packer.sv
module tb_pixel_line_packer;

  localparam int PW = 24;
  localparam int LP = 64;
  localparam int LW = PW * LP;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [23:0]   base_address = '0;
  logic          pixel_valid = 1'b0;
  logic [PW-1:0] pixel_data = '0;
  logic          pixel_ready;
  logic          flush = 1'b0;
  logic [LW-1:0] write_data;
  logic [23:0]   address;
  logic          write_enable;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [23:0]   addr;
    logic [LW-1:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_exp = 0;

  pixel_line_packer #(
    .PIXEL_W    (PW),
    .LINE_PIXELS(LP),
    .FRAME_WORDS(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_address(base_address),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .pixel_ready (pixel_ready),
    .flush       (flush),
    .write_data  (write_data),
    .address     (address),
    .write_enable(write_enable),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] build_line(input logic [23:0] first, input int n);
    logic [LW-1:0] r;
    r = '1;
    for (int i = 0; i < n; i++) r[i*PW +: PW] = first + 24'(i);
    return r;
  endfunction

  // Scoreboard monitor: every write strobe and done pulse must match a queued expectation.
  always @(negedge clk) begin : monitor
    wr_t e;
    int  bad;
    if (!reset) begin
      if (write_enable) begin
        tests++;
        if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got addr %h, required no write", address);
        end else begin
          e = wr_q.pop_front();
          bad = -1;
          for (int k = LP - 1; k >= 0; k--)
            if (write_data[k*PW +: PW] !== e.data[k*PW +: PW]) bad = k;
          if (address !== e.addr || bad >= 0) begin
            fails++;
            if (bad < 0) bad = 0;
            $display("FAIL write_word: addr got %h req %h, slot %0d got %h req %h",
                     address, e.addr, bad, write_data[bad*PW +: PW], e.data[bad*PW +: PW]);
          end
        end
      end
      if (done) begin
        tests++;
        if (done_exp == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done=1, required 0");
        end else begin
          done_exp--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic do_start(input logic [23:0] b);
    start = 1'b1;
    base_address = b;
    tick();
    start = 1'b0;
  endtask

  task automatic push_pix(input logic [23:0] d, input logic fl);
    int guard;
    guard = 0;
    pixel_valid = 1'b1;
    pixel_data = d;
    flush = fl;
    while (!pixel_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      tests++;
      fails++;
      $display("FAIL pixel_ready_timeout: got 0 required 1");
    end
    tick();
    pixel_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send_pixels(input logic [23:0] first, input int n, input logic flush_last);
    for (int i = 0; i < n; i++) push_pix(first + 24'(i), flush_last && (i == n - 1));
  endtask

  task automatic flush_only();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, pixel_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, write_enable}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_addr"}, {8'd0, address}, 32'd0);
    check({tag, "_wdata_ones"}, {31'd0, &write_data}, 32'd1);
  endtask

  // One full line at base 0x100 with slot i = i, then an empty flush to end the frame.
  task automatic basic_line();
    do_start(24'h000100);
    check("b_busy", {31'd0, busy}, 32'd1);
    wr_q.push_back('{addr: 24'h000100, data: build_line(24'h0, 64)});
    send_pixels(24'h0, 64, 1'b0);
    check("b_we_latency", {31'd0, write_enable}, 32'd1);
    check("b_ready_low", {31'd0, pixel_ready}, 32'd0);
    tick();
    check("b_ready_high", {31'd0, pixel_ready}, 32'd1);
    check("b_next_addr", {8'd0, address}, 32'h000140);
    done_exp++;
    flush_only();
    check("b_empty_flush_done", {31'd0, done}, 32'd1);
    check("b_empty_flush_no_we", {31'd0, write_enable}, 32'd0);
    tick();
    check("b_busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic two_word_frame(input logic [23:0] base, input logic [23:0] second_addr);
    do_start(base);
    wr_q.push_back('{addr: base, data: build_line(24'h000100, 64)});
    wr_q.push_back('{addr: second_addr, data: build_line(24'h000200, 64)});
    done_exp++;
    send_pixels(24'h000100, 64, 1'b0);
    send_pixels(24'h000200, 64, 1'b0);
    check("f_we_second", {31'd0, write_enable}, 32'd1);
    tick();
    check("f_done_pulse", {31'd0, done}, 32'd1);
    tick();
    check("f_done_one_cycle", {31'd0, done}, 32'd0);
    check("f_busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    basic_line();

    // Two-word frame from base 0
    two_word_frame(24'h000000, 24'h000040);

    // Partial line + flush; a start mid-frame must not move the address
    do_start(24'h002000);
    wr_q.push_back('{addr: 24'h002000, data: build_line(24'hAA0000, 5)});
    send_pixels(24'hAA0000, 2, 1'b0);
    do_start(24'h999999);
    send_pixels(24'hAA0002, 3, 1'b0);
    done_exp++;
    flush_only();
    check("p_we_after_flush", {31'd0, write_enable}, 32'd1);
    check("p_addr_kept", {8'd0, address}, 32'h002000);
    tick();
    check("p_done", {31'd0, done}, 32'd1);
    tick();

    // Flush on the 64th pixel: single full write then done
    do_start(24'h000300);
    wr_q.push_back('{addr: 24'h000300, data: build_line(24'h123400, 64)});
    done_exp++;
    send_pixels(24'h123400, 64, 1'b1);
    check("l_we", {31'd0, write_enable}, 32'd1);
    tick();
    check("l_done_no_more_fill", {31'd0, done}, 32'd1);
    tick();
    tick();
    check("l_idle", {31'd0, busy}, 32'd0);

    // Address wraps modulo 2^24
    two_word_frame(24'hFFFFC0, 24'h000000);

    // Reset after 30 pixels discards the partial line
    do_start(24'h000500);
    send_pixels(24'h00BB00, 30, 1'b0);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid");
    tick();
    reset = 1'b0;
    tick();
    basic_line();

    tick();
    tick();
    check("sb_writes_drained", 32'(wr_q.size()), 32'd0);
    check("sb_dones_drained", 32'(done_exp), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_line_packer.md
PIXEL_LINE_PACKER -- requirements
Module: pixel_line_packer

Interface
REQ-001 SHALL have parameter PIXEL_W, default 24, meaning bits per RGB pixel.
REQ-002 SHALL have parameter LINE_PIXELS, default 64, meaning pixels packed per SRAM write word.
REQ-003 SHALL have parameter FRAME_WORDS, default 3264, meaning write words per frame (3264*64 = 208896 pixels).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-008 base_address  input  24  first SRAM word address of the frame; captured on accepted start.
REQ-009 pixel_valid  input  1  upstream pixel present.
REQ-010 pixel_data  input  PIXEL_W  upstream pixel value.
REQ-011 pixel_ready  output  1  block accepts a pixel this cycle.
REQ-012 flush  input  1  end the frame early; partial line is padded and written.
REQ-013 write_data  output  LINE_PIXELS*PIXEL_W  packed line to the SRAM; slot i at bits [PIXEL_W*i+PIXEL_W-1 : PIXEL_W*i].
REQ-014 address  output  24  SRAM address for write_data.
REQ-015 write_enable  output  1  one-cycle SRAM write strobe.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on frame completion.

Function
REQ-018 SHALL implement states IDLE, FILL, WRITE, DONE.
REQ-019 IDLE: pixel_ready=0; on start -> FILL, address<=base_address, fill_cnt<=0, word_cnt<=0, buffer<=all ones.
REQ-020 start while not IDLE SHALL be ignored.
REQ-021 FILL: pixel_ready=1; a pixel is accepted iff pixel_valid && pixel_ready, written into slot fill_cnt, fill_cnt incremented.
REQ-022 Acceptance of slot LINE_PIXELS-1 SHALL move to WRITE next cycle; pixel_ready is 0 in WRITE and DONE.
REQ-023 WRITE: write_enable=1 for exactly one cycle with registered write_data and address stable that cycle.
REQ-024 On leaving WRITE: address<=address+LINE_PIXELS (modulo 2^24, wraps silently), word_cnt+1, fill_cnt<=0, buffer<=all ones.
REQ-025 After WRITE: -> DONE if word_cnt+1==FRAME_WORDS or flush_pending set, else -> FILL.
REQ-026 flush in FILL with fill_cnt==0 and no pixel accepted that cycle SHALL go directly to DONE with no write.
REQ-027 flush in FILL with fill_cnt>0 SHALL go to WRITE; unfilled slots keep 24'hFFFFFF padding.
REQ-028 flush and an accepted pixel in the same cycle: pixel is stored first, then flush applies; flush_pending set so the resulting write is the last.
REQ-029 flush outside FILL SHALL be ignored.
REQ-030 DONE: done=1 for one cycle, then -> IDLE; busy falls the cycle after done.
REQ-031 Latency: write_enable asserts the cycle after the 64th pixel is accepted.
REQ-032 Throughput: 64 pixels then one WRITE cycle; pixel_ready low exactly one cycle per line.

Reset
REQ-033 On reset, next edge: state IDLE, pixel_ready=0, write_enable=0, done=0, busy=0, address=0, write_data all ones, fill_cnt=0, word_cnt=0, flush_pending=0.
REQ-034 Reset mid-frame (including during WRITE) SHALL abort with no further write_enable; partial line discarded.

Verification
REQ-035 start, base_address=0x000100, 64 pixels 0..63 back-to-back -> one write_enable, address=0x000100, slot i=i, pixel_ready low one cycle, then high again.
REQ-036 FRAME_WORDS=2, base 0, 128 pixels -> writes at 0x000000 and 0x000040, done pulse one cycle after second write, busy low after.
REQ-037 5 pixels 0xAA0000..0xAA0004 then flush -> one write, slots 0-4 data, slots 5-63 = 0xFFFFFF, then done.
REQ-038 64th pixel accepted with flush same cycle -> single full write, then DONE, no extra write.
REQ-039 base_address=0xFFFFC0, FRAME_WORDS=2 -> writes at 0xFFFFC0 then 0x000000.
REQ-040 reset asserted after 30 pixels -> no write_enable, outputs at reset values; new start then behaves per REQ-035.
